fifo_push_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares the single push port of a byte FIFO among several byte producers. A requester that wins arbitration owns the push port until it sends a byte marked last, so packets stay contiguous in the FIFO. Ownership is forcibly ended after a configurable burst length to bound starvation. Sits directly in front of the FIFO and drives its `cByte`/`cPush` inputs from its `hFull` output.

---
 rtl/arb_pkg.sv | 11 +
 rtl/fifo_push_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_push_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the packet-aware FIFO push arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    localparam int ArbMaxRequesters = 8;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first requester after index `last_i`, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0] pos;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = N; k >= 1; k--) begin
            pos = {1'b0, last_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (req_i[pos[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port; a winner keeps the port
// until its packet ends or its burst limit is reached.
module fifo_push_arbiter
    import arb_pkg::*;
#(
    parameter int Requesters = 4,
    parameter int MaxBurst   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [Requesters-1:0]         rValid,
    input  logic [8*Requesters-1:0]       rByte,
    input  logic [Requesters-1:0]         rLast,
    output logic [Requesters-1:0]         rAck,
    output logic [7:0]                    fByte,
    output logic                          fPush,
    input  logic                          fFull,
    output logic [$clog2(Requesters)-1:0] hOwner,
    output logic                          hBusy,
    output logic                          hAbort
);

    localparam int IW = $clog2(Requesters);
    localparam int CW = $clog2(MaxBurst + 1);

    arb_state_e    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          abort_q;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] sel_idx;
    logic          sel_ok;
    logic          sel_last;
    logic          push;
    logic [7:0]    byte_arr [Requesters];

    rr_pick #(
        .N  (Requesters),
        .IW (IW)
    ) u_pick (
        .req_i   (rValid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < Requesters; gi++) begin : g_req
            assign byte_arr[gi] = rByte[8*gi +: 8];
            assign rAck[gi]     = push && (sel_idx == IW'(gi));
        end
    endgenerate

    // While owned, only the owner may push, even if it is idle this cycle.
    always_comb begin
        if (state_q == ARB_OWNED) begin
            sel_idx = owner_q;
            sel_ok  = rValid[owner_q];
        end else begin
            sel_idx = pick_idx;
            sel_ok  = pick_found;
        end
        sel_last = rLast[sel_idx];
        push     = reset && sel_ok && !fFull;
        fByte    = push ? byte_arr[sel_idx] : 8'h00;
        count_d  = count_q + CW'(1);
    end

    assign fPush  = push;
    assign hOwner = owner_q;
    assign hBusy  = (state_q == ARB_OWNED);
    assign hAbort = abort_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IW'(Requesters - 1);
            count_q <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (push) begin
                last_q <= sel_idx;
                if (state_q == ARB_IDLE) begin
                    count_q <= CW'(1);
                    if (!sel_last) begin
                        if (MaxBurst == 1) begin
                            abort_q <= 1'b1;
                        end else begin
                            state_q <= ARB_OWNED;
                            owner_q <= sel_idx;
                        end
                    end
                end else begin
                    count_q <= count_d;
                    // A byte marked last ends the packet cleanly even on the limit.
                    if (sel_last || count_d == CW'(MaxBurst)) begin
                        state_q <= ARB_IDLE;
                        abort_q <= !sel_last;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed table-driven bench for fifo_push_arbiter (4 requesters, burst limit 4).
module tb_fifo_push_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  rValid;
    logic [31:0] rByte;
    logic [3:0]  rLast;
    logic [3:0]  rAck;
    logic [7:0]  fByte;
    logic        fPush;
    logic        fFull;
    logic [1:0]  hOwner;
    logic        hBusy;
    logic        hAbort;

    int total = 0;
    int bad   = 0;

    fifo_push_arbiter #(
        .Requesters (4),
        .MaxBurst   (4)
    ) dut (
        .clock  (clk),
        .reset  (reset),
        .rValid (rValid),
        .rByte  (rByte),
        .rLast  (rLast),
        .rAck   (rAck),
        .fByte  (fByte),
        .fPush  (fPush),
        .fFull  (fFull),
        .hOwner (hOwner),
        .hBusy  (hBusy),
        .hAbort (hAbort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] bytes;
        logic        full;
        logic [3:0]  ack;
        logic [7:0]  fb;
        logic        busy;
        logic [1:0]  owner;
        logic        abort;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                                input logic [31:0] bytes, input logic full, input logic [3:0] ack,
                                input logic [7:0] fb, input logic busy, input logic [1:0] owner,
                                input logic abort);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.bytes = bytes; v.full = full;
        v.ack = ack; v.fb = fb; v.busy = busy; v.owner = owner; v.abort = abort;
        return v;
    endfunction

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        reset  = v.rst;
        rValid = v.valid;
        rLast  = v.last;
        rByte  = v.bytes;
        fFull  = v.full;
        #3;
        chk("rAck",   n, {28'b0, rAck},   {28'b0, v.ack});
        chk("fPush",  n, {31'b0, fPush},  {31'b0, |v.ack});
        chk("fByte",  n, {24'b0, fByte},  {24'b0, v.fb});
        chk("hBusy",  n, {31'b0, hBusy},  {31'b0, v.busy});
        chk("hAbort", n, {31'b0, hAbort}, {31'b0, v.abort});
        if (v.busy) begin
            chk("hOwner", n, {30'b0, hOwner}, {30'b0, v.owner});
        end
        $display("vec %0d: rst=%b valid=%b full=%b -> ack=%b push=%b byte=%h busy=%b owner=%0d abort=%b",
                 n, v.rst, v.valid, v.full, rAck, fPush, fByte, hBusy, hOwner, hAbort);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // reset with everyone requesting: outputs forced low
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 8'h00, 0, 0, 0));
        // round robin of single-byte packets: 0,1,2,3,0
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0001, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0010, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0100, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b1000, 8'h44, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0001, 8'h11, 0, 0, 0));
        // single byte from requester 0, then nothing requested
        vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000A5, 0, 4'b0001, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 8'h00, 0, 0, 0));
        // packet lock: req1 sends 11,22,33 while req2 waits; owner idle cycle ignores req2
        vecs.push_back(mk(1, 4'b0110, 4'b0100, 32'h00991100, 0, 4'b0010, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 32'h00990000, 0, 4'b0000, 8'h00, 1, 1, 0));
        vecs.push_back(mk(1, 4'b0110, 4'b0100, 32'h00992200, 0, 4'b0010, 8'h22, 1, 1, 0));
        vecs.push_back(mk(1, 4'b0110, 4'b0110, 32'h00993300, 0, 4'b0010, 8'h33, 1, 1, 0));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 32'h00990000, 0, 4'b0100, 8'h99, 0, 0, 0));
        // backpressure mid-packet from req3
        vecs.push_back(mk(1, 4'b1001, 4'b0001, 32'hC100000F, 0, 4'b1000, 8'hC1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, 4'b1001, 4'b0001, 32'hC200000F, 1, 4'b0000, 8'h00, 1, 3, 0));
        end
        vecs.push_back(mk(1, 4'b1001, 4'b0001, 32'hC200000F, 0, 4'b1000, 8'hC2, 1, 3, 0));
        vecs.push_back(mk(1, 4'b1001, 4'b1001, 32'hC300000F, 0, 4'b1000, 8'hC3, 1, 3, 0));
        // burst limit: req0 streams 4 bytes, then req1 granted with abort pulse
        vecs.push_back(mk(1, 4'b0011, 4'b0000, 32'h0000E1D1, 0, 4'b0001, 8'hD1, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0011, 4'b0000, 32'h0000E1D2, 0, 4'b0001, 8'hD2, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0011, 4'b0000, 32'h0000E1D3, 0, 4'b0001, 8'hD3, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0011, 4'b0000, 32'h0000E1D4, 0, 4'b0001, 8'hD4, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0011, 4'b0000, 32'h0000E1D5, 0, 4'b0010, 8'hE1, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000E200, 0, 4'b0010, 8'hE2, 1, 1, 0));
        // reset mid-packet of req2, then req0 wins after release
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h00F10000, 0, 4'b0100, 8'hF1, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0101, 32'h00F200A0, 0, 4'b0000, 8'h00, 1, 2, 0));
        vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00F200A0, 0, 4'b0001, 8'hA0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 32'h00F20000, 0, 4'b0100, 8'hF2, 0, 0, 0));
        // full while idle: no push, pointer unchanged
        vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B0, 1, 4'b0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B0, 0, 4'b0001, 8'hB0, 0, 0, 0));

        reset  = 1'b0;
        rValid = '0;
        rLast  = '0;
        rByte  = '0;
        fFull  = 1'b0;
        @(posedge clk);
        #1;

        n = 0;
        foreach (vecs[i]) begin
            run_vec(vecs[i], n);
            n++;
        end

        // Burst limit with no other requester: abort pulses exactly one cycle.
        for (int k = 0; k < 4; k++) begin
            run_vec(mk(1, 4'b0100, 4'b0000, {8'h00, 8'h60 + 8'(k), 16'h0000}, 0,
                       4'b0100, 8'h60 + 8'(k), (k > 0), 2, 0), n);
            n++;
        end
        run_vec(mk(1, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 8'h00, 0, 0, 1), n);
        n++;
        run_vec(mk(1, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 8'h00, 0, 0, 0), n);
        n++;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
